// File: rtl/wb_cmd_pkg.sv
// wb_cmd_pkg: shared state encoding and response status codes for wb_cmd_master.
package wb_cmd_pkg;
   typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;
   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_BERR = 2'b01;
   localparam logic [1:0] ST_TMO  = 2'b10;
endpackage

// File: rtl/wb_cmd_if.sv
// wb_cmd_if: command/response handshake plus Wishbone classic master signals.
interface wb_cmd_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic          cmd_we_i;
   logic [AW-1:0] cmd_adr_i;
   logic [DW-1:0] cmd_dat_i;
   logic [DW/8-1:0] cmd_sel_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [DW-1:0] rsp_dat_o;
   logic [1:0]    rsp_status_o;
   logic          wbm_cyc_o;
   logic          wbm_stb_o;
   logic          wbm_we_o;
   logic [DW/8-1:0] wbm_sel_o;
   logic [AW-1:0] wbm_adr_o;
   logic [DW-1:0] wbm_dat_o;
   logic [DW-1:0] wbm_dat_i;
   logic          wbm_ack_i;
   logic          wbm_err_i;
   modport master (
      input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
             wbm_dat_i, wbm_ack_i, wbm_err_i,
      output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
   );
   modport slave (
      output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
             wbm_dat_i, wbm_ack_i, wbm_err_i,
      input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
   );
endinterface

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: saturating bus-cycle counter flagging TIMEOUT-1 reached.
module wb_timeout_cnt #(
   parameter int TIMEOUT = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT);
   logic [W-1:0] cnt;
   assign expired = cnt == W'(TIMEOUT - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: turns single valid/ready commands into one Wishbone classic cycle each,
// returning read data and an OK / bus-error / timeout status.
module wb_cmd_master
   import wb_cmd_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 256
) (
   input logic      wb_clk_i,
   input logic      wb_rst_ni,
   wb_cmd_if.master bus
);
   state_t state;
   logic   expired;
   wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk    (wb_clk_i),
      .rst_n  (wb_rst_ni),
      .clr    (state != BUS),
      .en     (state == BUS),
      .expired(expired)
   );
   // Bus fields live directly in the output registers, so they are zero whenever cyc is low.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
      if (!wb_rst_ni) begin
         state            <= IDLE;
         bus.cmd_ready_o  <= 1'b1;
         bus.rsp_valid_o  <= 1'b0;
         bus.rsp_dat_o    <= '0;
         bus.rsp_status_o <= ST_OK;
         bus.wbm_cyc_o    <= 1'b0;
         bus.wbm_stb_o    <= 1'b0;
         bus.wbm_we_o     <= 1'b0;
         bus.wbm_sel_o    <= '0;
         bus.wbm_adr_o    <= '0;
         bus.wbm_dat_o    <= '0;
      end else begin
         case (state)
            IDLE: if (bus.cmd_valid_i) begin
               state           <= BUS;
               bus.cmd_ready_o <= 1'b0;
               bus.wbm_cyc_o   <= 1'b1;
               bus.wbm_stb_o   <= 1'b1;
               bus.wbm_we_o    <= bus.cmd_we_i;
               bus.wbm_sel_o   <= bus.cmd_sel_i;
               bus.wbm_adr_o   <= bus.cmd_adr_i;
               bus.wbm_dat_o   <= bus.cmd_we_i ? bus.cmd_dat_i : '0;
            end
            BUS: if (bus.wbm_err_i || bus.wbm_ack_i || expired) begin
               state            <= RSP;
               bus.rsp_valid_o  <= 1'b1;
               bus.rsp_status_o <= bus.wbm_err_i ? ST_BERR : bus.wbm_ack_i ? ST_OK : ST_TMO;
               bus.rsp_dat_o    <= (!bus.wbm_err_i && bus.wbm_ack_i && !bus.wbm_we_o) ? bus.wbm_dat_i : '0;
               bus.wbm_cyc_o    <= 1'b0;
               bus.wbm_stb_o    <= 1'b0;
               bus.wbm_we_o     <= 1'b0;
               bus.wbm_sel_o    <= '0;
               bus.wbm_adr_o    <= '0;
               bus.wbm_dat_o    <= '0;
            end
            RSP: if (bus.rsp_ready_i) begin
               state            <= IDLE;
               bus.cmd_ready_o  <= 1'b1;
               bus.rsp_valid_o  <= 1'b0;
               bus.rsp_dat_o    <= '0;
               bus.rsp_status_o <= ST_OK;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed checks of wb_cmd_master with TIMEOUT=16; inputs change and
// outputs are sampled on the falling edge.
module tb_wb_cmd_master;
   logic wb_clk_i = 1'b0;
   logic wb_rst_ni = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   n;
   wb_cmd_if #(.AW(32), .DW(32)) bus ();
   wb_cmd_master #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_ni(wb_rst_ni),
      .bus      (bus)
   );
   always #5 wb_clk_i = ~wb_clk_i;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(negedge wb_clk_i);
   endtask
   // Present a command for one cycle; returns at the first falling edge of the bus cycle.
   task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = we;
      bus.cmd_adr_i   = adr;
      bus.cmd_dat_i   = dat;
      bus.cmd_sel_i   = sel;
      step();
      bus.cmd_valid_i = 1'b0;
   endtask
   task automatic handshake();
      bus.rsp_ready_i = 1'b1;
      step();
      bus.rsp_ready_i = 1'b0;
   endtask
   initial begin
      bus.cmd_valid_i = 1'b0;
      bus.cmd_we_i    = 1'b0;
      bus.cmd_adr_i   = '0;
      bus.cmd_dat_i   = '0;
      bus.cmd_sel_i   = '0;
      bus.rsp_ready_i = 1'b0;
      bus.wbm_dat_i   = '0;
      bus.wbm_ack_i   = 1'b0;
      bus.wbm_err_i   = 1'b0;
      step();
      step();
      chk("rst_ready", 32'(bus.cmd_ready_o), 32'd1);
      chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("rst_adr", bus.wbm_adr_o, 32'd0);
      wb_rst_ni = 1'b1;
      step();
      // 1: write, ack on the third bus cycle
      issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
      for (int i = 0; i < 3; i++) begin
         chk("t1_cyc", {30'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'd3);
         chk("t1_adr", bus.wbm_adr_o, 32'h3000_0004);
         chk("t1_dat", bus.wbm_dat_o, 32'hDEAD_BEEF);
         chk("t1_we_sel", {27'd0, bus.wbm_we_o, bus.wbm_sel_o}, 32'h1F);
         chk("t1_ready", 32'(bus.cmd_ready_o), 32'd0);
         if (i == 2) bus.wbm_ack_i = 1'b1;
         step();
      end
      bus.wbm_ack_i = 1'b0;
      chk("t1_cyc_drop", {30'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'd0);
      chk("t1_fields_zero", bus.wbm_adr_o | bus.wbm_dat_o, 32'd0);
      chk("t1_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("t1_status", 32'(bus.rsp_status_o), 32'd0);
      chk("t1_rsp_dat", bus.rsp_dat_o, 32'd0);
      step();
      chk("t1_rsp_hold", 32'(bus.rsp_valid_o), 32'd1);
      handshake();
      chk("t1_after_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("t1_after_ready", 32'(bus.cmd_ready_o), 32'd1);
      // 2: read, ack in first bus cycle
      issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
      chk("t2_cyc", 32'(bus.wbm_cyc_o), 32'd1);
      chk("t2_no_rsp_yet", 32'(bus.rsp_valid_o), 32'd0);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'h0000_1234;
      step();
      bus.wbm_ack_i = 1'b0;
      bus.wbm_dat_i = 32'h0;
      chk("t2_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("t2_rsp_dat", bus.rsp_dat_o, 32'h0000_1234);
      chk("t2_status", 32'(bus.rsp_status_o), 32'd0);
      handshake();
      // 4b: spurious ack/err while idle
      bus.wbm_ack_i = 1'b1;
      bus.wbm_err_i = 1'b1;
      step();
      step();
      bus.wbm_ack_i = 1'b0;
      bus.wbm_err_i = 1'b0;
      chk("idle_spur_cyc", 32'(bus.wbm_cyc_o), 32'd0);
      chk("idle_spur_rsp", 32'(bus.rsp_valid_o), 32'd0);
      chk("idle_spur_ready", 32'(bus.cmd_ready_o), 32'd1);
      // 3: read timeout, nonzero dat_i must not leak into the response
      bus.wbm_dat_i = 32'hFFFF_FFFF;
      issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
      n = 0;
      while (bus.wbm_cyc_o && n < 100) begin
         n++;
         step();
      end
      bus.wbm_dat_i = 32'h0;
      chk("t3_bus_cycles", 32'(n), 32'd16);
      chk("t3_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("t3_status", 32'(bus.rsp_status_o), 32'd2);
      chk("t3_rsp_dat", bus.rsp_dat_o, 32'd0);
      handshake();
      // 4: ack and err together -> bus error
      issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_err_i = 1'b1;
      bus.wbm_dat_i = 32'h55;
      step();
      bus.wbm_ack_i = 1'b0;
      bus.wbm_err_i = 1'b0;
      bus.wbm_dat_i = 32'h0;
      chk("t4_status", 32'(bus.rsp_status_o), 32'd1);
      chk("t4_rsp_dat", bus.rsp_dat_o, 32'd0);
      // 5: stalled response with a waiting command
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = 1'b1;
      bus.cmd_adr_i   = 32'h3000_0008;
      bus.cmd_dat_i   = 32'h0000_00A5;
      bus.cmd_sel_i   = 4'h1;
      for (int i = 0; i < 5; i++) begin
         chk("t5_ready_low", 32'(bus.cmd_ready_o), 32'd0);
         chk("t5_rsp_stable", {29'd0, bus.rsp_valid_o, bus.rsp_status_o}, 32'h5);
         chk("t5_no_cyc", 32'(bus.wbm_cyc_o), 32'd0);
         step();
      end
      handshake();
      chk("t5_ready_back", 32'(bus.cmd_ready_o), 32'd1);
      chk("t5_still_idle", 32'(bus.wbm_cyc_o), 32'd0);
      step();
      bus.cmd_valid_i = 1'b0;
      chk("t5_taken", 32'(bus.wbm_cyc_o), 32'd1);
      chk("t5_adr", bus.wbm_adr_o, 32'h3000_0008);
      chk("t5_sel", 32'(bus.wbm_sel_o), 32'h1);
      bus.wbm_ack_i = 1'b1;
      step();
      bus.wbm_ack_i = 1'b0;
      chk("t5_status", 32'(bus.rsp_status_o), 32'd0);
      handshake();
      // 6: reset mid bus cycle
      issue(1'b1, 32'h3000_000C, 32'h1111_2222, 4'hF);
      chk("t6_cyc_pre", 32'(bus.wbm_cyc_o), 32'd1);
      #2 wb_rst_ni = 1'b0;
      #1;
      chk("t6_cyc_async", {30'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'd0);
      step();
      step();
      wb_rst_ni = 1'b1;
      chk("t6_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
      chk("t6_ready", 32'(bus.cmd_ready_o), 32'd1);
      step();
      issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
      chk("t6_clean_adr", bus.wbm_adr_o, 32'h3000_0000);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'hCAFE_0001;
      step();
      bus.wbm_ack_i = 1'b0;
      chk("t6_clean_dat", bus.rsp_dat_o, 32'hCAFE_0001);
      chk("t6_clean_status", {29'd0, bus.rsp_valid_o, bus.rsp_status_o}, 32'h4);
      handshake();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
